// File: rtl/jtag_pkg.sv
// JTAG TAP state encoding, default opcodes and fixed register widths.
// Shared by the target-side TAP and by initiator-side models.
package jtag_pkg;

    // Standard 1149.1 state encoding
    typedef enum logic [3:0] {
        ST_EXIT2_DR = 4'h0,
        ST_EXIT1_DR = 4'h1,
        ST_SHIFT_DR = 4'h2,
        ST_PAUSE_DR = 4'h3,
        ST_SEL_IR   = 4'h4,
        ST_UPD_DR   = 4'h5,
        ST_CAP_DR   = 4'h6,
        ST_SEL_DR   = 4'h7,
        ST_EXIT2_IR = 4'h8,
        ST_EXIT1_IR = 4'h9,
        ST_SHIFT_IR = 4'hA,
        ST_PAUSE_IR = 4'hB,
        ST_RTI      = 4'hC,
        ST_UPD_IR   = 4'hD,
        ST_CAP_IR   = 4'hE,
        ST_TLR      = 4'hF
    } tap_state_t;

    localparam int         IDCODE_W      = 32;
    localparam int         IR_W_DEF      = 10;
    localparam logic [9:0] OP_IDCODE_DEF = 10'h001;
    localparam logic [9:0] OP_USER_DEF   = 10'h002;
    localparam logic [9:0] OP_BYPASS_DEF = 10'h3FF;

    function automatic logic is_shift_state(tap_state_t s);
        return (s == ST_SHIFT_DR) || (s == ST_SHIFT_IR);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// Combinational 1149.1 TAP next-state function: (state, tms) -> next state.
// No storage; the caller decides when a tck rise commits the transition.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  tap_state_t state,
    input  logic       tms,
    output tap_state_t next_state
);

    always_comb begin
        next_state = state;
        case (state)
            ST_TLR:      next_state = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      next_state = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   next_state = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   next_state = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: next_state = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: next_state = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: next_state = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: next_state = tms ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   next_state = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   next_state = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   next_state = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: next_state = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: next_state = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: next_state = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: next_state = tms ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   next_state = tms ? ST_SEL_DR   : ST_RTI;
        endcase
    end

endmodule

// File: rtl/jtag_tap_target.sv
// Target-side JTAG TAP with IR, BYPASS, IDCODE and a USER register bridged to TX/RX FIFOs.
// tck pin edge to register update is 3 clk; a full RX FIFO drops the Update-DR and sets sticky overflow.
module jtag_tap_target
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH   = IR_W_DEF,
    parameter int                    DR_WIDTH   = 8,
    parameter logic [IDCODE_W-1:0]   IDCODE_VAL = 32'h1234_5001,
    parameter logic [IR_WIDTH-1:0]   OP_IDCODE  = IR_WIDTH'(OP_IDCODE_DEF),
    parameter logic [IR_WIDTH-1:0]   OP_USER    = IR_WIDTH'(OP_USER_DEF),
    parameter logic [IR_WIDTH-1:0]   OP_BYPASS  = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_oe,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir,
    input  logic [DR_WIDTH-1:0] rdata_user,
    input  logic                empty_user,
    output logic                rd_user,
    output logic [DR_WIDTH-1:0] wdata_user,
    input  logic                full_user,
    output logic                wr_user,
    output logic                overflow
);

    logic [2:0] tck_s;
    logic [2:0] tms_s;
    logic [2:0] tdi_s;
    logic       rise;
    logic       fall;
    logic       tms_q;
    logic       tdi_q;

    tap_state_t state;
    tap_state_t state_nxt;
    tap_state_t fsm_next;

    logic [IR_WIDTH-1:0] ir_shift;
    logic [DR_WIDTH-1:0] dr_shift;
    logic [IDCODE_W-1:0] id_shift;
    logic                bypass_reg;
    logic                sel_id;
    logic                sel_user;
    logic                dr_msb;

    // All three pins share one pipeline so tms/tdi stay aligned with the tck edge
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_s <= 3'b000;
            tms_s <= 3'b111;
            tdi_s <= 3'b000;
        end else begin
            tck_s <= {tck_s[1:0], tck};
            tms_s <= {tms_s[1:0], tms};
            tdi_s <= {tdi_s[1:0], tdi};
        end
    end

    assign rise  =  tck_s[1] & ~tck_s[2];
    assign fall  = ~tck_s[1] &  tck_s[2];
    // Third stage holds the value sampled while tck was still on its old level
    assign tms_q = tms_s[2];
    assign tdi_q = tdi_s[2];

    jtag_tap_fsm u_fsm (
        .state      (state),
        .tms        (tms_q),
        .next_state (fsm_next)
    );

    always_comb begin
        state_nxt = state;
        if (rise) begin
            state_nxt = fsm_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_TLR;
        end else begin
            state <= state_nxt;
        end
    end

    assign tap_state = state;

    // An explicit BYPASS opcode wins if the opcode parameters ever overlap
    assign sel_id   = (ir == OP_IDCODE) && (ir != OP_BYPASS);
    assign sel_user = (ir == OP_USER)   && (ir != OP_BYPASS);

    always_comb begin
        dr_msb = bypass_reg;
        if (sel_user) begin
            dr_msb = dr_shift[DR_WIDTH-1];
        end else if (sel_id) begin
            dr_msb = id_shift[IDCODE_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir         <= OP_IDCODE;
            ir_shift   <= '0;
            dr_shift   <= '0;
            id_shift   <= '0;
            bypass_reg <= 1'b0;
            tdo        <= 1'b0;
            tdo_oe     <= 1'b0;
            rd_user    <= 1'b0;
            wr_user    <= 1'b0;
            wdata_user <= '0;
            overflow   <= 1'b0;
        end else begin
            rd_user <= 1'b0;
            wr_user <= 1'b0;

            // Rise actions are keyed on the state being left
            if (rise) begin
                case (state)
                    ST_CAP_IR: begin
                        ir_shift <= IR_WIDTH'(1);
                    end
                    ST_SHIFT_IR: begin
                        ir_shift <= {ir_shift[IR_WIDTH-2:0], tdi_q};
                    end
                    ST_CAP_DR: begin
                        if (sel_user) begin
                            if (!empty_user) begin
                                dr_shift <= rdata_user;
                                rd_user  <= 1'b1;
                            end else begin
                                dr_shift <= '0;
                            end
                        end else if (sel_id) begin
                            id_shift <= IDCODE_VAL;
                        end else begin
                            bypass_reg <= 1'b0;
                        end
                    end
                    ST_SHIFT_DR: begin
                        if (sel_user) begin
                            dr_shift <= {dr_shift[DR_WIDTH-2:0], tdi_q};
                        end else if (sel_id) begin
                            id_shift <= {id_shift[IDCODE_W-2:0], tdi_q};
                        end else begin
                            bypass_reg <= tdi_q;
                        end
                    end
                    default: ;
                endcase
            end

            // Fall actions are keyed on the state just entered
            if (fall) begin
                tdo_oe <= is_shift_state(state);
                case (state)
                    ST_SHIFT_IR: tdo <= ir_shift[IR_WIDTH-1];
                    ST_SHIFT_DR: tdo <= dr_msb;
                    ST_UPD_IR:   ir  <= ir_shift;
                    ST_TLR:      ir  <= OP_IDCODE;
                    ST_UPD_DR: begin
                        if (sel_user) begin
                            if (!full_user) begin
                                wdata_user <= dr_shift;
                                wr_user    <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed bench for jtag_tap_target: driver pushes expected tdo bits and FIFO strobes,
// independent monitors pop and compare whenever the DUT presents them.
module tb_jtag_tap_target;
    import jtag_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tck;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_oe;
    logic [3:0] tap_state;
    logic [9:0] ir;
    logic [7:0] rdata_user;
    logic       empty_user;
    logic       rd_user;
    logic [7:0] wdata_user;
    logic       full_user;
    logic       wr_user;
    logic       overflow;

    logic       exp_tdo[$];
    logic [7:0] exp_wr[$];
    bit         exp_rd[$];
    logic       e_tdo;
    logic [7:0] e_wr;
    bit         e_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtag_tap_target dut (
        .clk        (clk),
        .rst        (rst),
        .tck        (tck),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_oe     (tdo_oe),
        .tap_state  (tap_state),
        .ir         (ir),
        .rdata_user (rdata_user),
        .empty_user (empty_user),
        .rd_user    (rd_user),
        .wdata_user (wdata_user),
        .full_user  (full_user),
        .wr_user    (wr_user),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // tdo is sampled at each tck rise while the DUT drives it
    always @(posedge tck) begin
        if (tdo_oe) begin
            if (exp_tdo.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tdo_oe: got 1 with no scan bit expected, expected 0");
            end else begin
                e_tdo = exp_tdo.pop_front();
                check("tdo", 32'(tdo), 32'(e_tdo));
            end
        end
    end

    always @(negedge clk) begin
        if (wr_user) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_user: got pulse (wdata %h), expected none", wdata_user);
            end else begin
                e_wr = exp_wr.pop_front();
                check("wdata_user", 32'(wdata_user), 32'(e_wr));
            end
        end
    end

    always @(negedge clk) begin
        if (rd_user) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_user: got pulse, expected none");
            end else begin
                e_rd = exp_rd.pop_front();
                check("rd_user", 32'(rd_user), 32'(e_rd));
            end
        end
    end

    // One tck period of 8 clk: fall, 4 clk low, rise, 4 clk high
    task automatic tck_cycle(input logic m, input logic d);
        @(negedge clk);
        tck = 1'b0;
        tms = m;
        tdi = d;
        repeat (4) @(negedge clk);
        tck = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // From Run-Test/Idle, load val into IR; cap is the expected captured pattern
    task automatic scan_ir(input logic [9:0] val, input logic [9:0] cap);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) exp_tdo.push_back(cap[9-i]);
        for (int i = 0; i < 10; i++) tck_cycle(i == 9, val[9-i]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle, shift n bits of val through the selected DR; cap is expected out
    task automatic scan_dr(input int n, input logic [31:0] val, input logic [31:0] cap);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < n; i++) exp_tdo.push_back(cap[n-1-i]);
        for (int i = 0; i < n; i++) tck_cycle(i == n - 1, val[n-1-i]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        tck        = 1'b0;
        tms        = 1'b1;
        tdi        = 1'b0;
        rdata_user = 8'hA5;
        empty_user = 1'b1;
        full_user  = 1'b0;
        rst        = 1'b1;
        repeat (4) @(negedge clk);

        check("rst tap_state",  32'(tap_state),  32'(ST_TLR));
        check("rst ir",         32'(ir),         32'h001);
        check("rst tdo",        32'(tdo),        32'h0);
        check("rst tdo_oe",     32'(tdo_oe),     32'h0);
        check("rst rd_user",    32'(rd_user),    32'h0);
        check("rst wr_user",    32'(wr_user),    32'h0);
        check("rst overflow",   32'(overflow),   32'h0);
        check("rst wdata_user", 32'(wdata_user), 32'h0);
        rst = 1'b0;

        tck_cycle(1'b0, 1'b0);
        check("state rti", 32'(tap_state), 32'(ST_RTI));

        // IDCODE is selected out of reset
        scan_dr(32, 32'h0, 32'h1234_5001);

        scan_ir(10'h002, 10'h001);
        check("ir user", 32'(ir), 32'h002);

        // USER loopback
        rdata_user = 8'hA5;
        empty_user = 1'b0;
        full_user  = 1'b0;
        exp_rd.push_back(1'b1);
        exp_wr.push_back(8'h3C);
        scan_dr(8, 32'h3C, 32'hA5);
        check("overflow after loopback", 32'(overflow), 32'h0);

        // TX empty: zero captured, no pop
        empty_user = 1'b1;
        exp_wr.push_back(8'h5A);
        scan_dr(8, 32'h5A, 32'h00);

        // RX full: push dropped, overflow set
        empty_user = 1'b0;
        full_user  = 1'b1;
        exp_rd.push_back(1'b1);
        scan_dr(8, 32'h77, 32'hA5);
        check("overflow set", 32'(overflow), 32'h1);

        full_user  = 1'b0;
        empty_user = 1'b1;
        exp_wr.push_back(8'hC3);
        scan_dr(8, 32'hC3, 32'h00);
        check("overflow sticky", 32'(overflow), 32'h1);

        // BYPASS via explicit and undecoded opcodes; a non-empty TX must not be popped
        empty_user = 1'b0;
        scan_ir(10'h3FF, 10'h001);
        check("ir bypass", 32'(ir), 32'h3FF);
        scan_dr(4, 32'hB, 32'h5);
        scan_ir(10'h155, 10'h001);
        check("ir undecoded", 32'(ir), 32'h155);
        scan_dr(4, 32'hB, 32'h5);

        // Five tms=1 rises from Shift-DR reach Test-Logic-Reset and restore IDCODE
        scan_ir(10'h002, 10'h001);
        empty_user = 1'b1;
        full_user  = 1'b1;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        check("state shift_dr", 32'(tap_state), 32'(ST_SHIFT_DR));
        exp_tdo.push_back(1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
        check("tlr tap_state", 32'(tap_state), 32'(ST_TLR));
        tck_cycle(1'b1, 1'b0);
        check("tlr ir", 32'(ir), 32'h001);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("overflow cleared by rst", 32'(overflow), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("tdo bits outstanding", 32'(exp_tdo.size()), 32'h0);
        check("rd pulses outstanding", 32'(exp_rd.size()), 32'h0);
        check("wr pulses outstanding", 32'(exp_wr.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
